// File: rtl/alu_pkg.sv
// Shared constants and helpers for the vector ALU lanes.
package alu_pkg;

    localparam logic ADD = 1'b0;
    localparam logic SUB = 1'b1;

    // Results are 64 bits wide; callers keep the low WIDTH bits (WIDTH <= 64).
    function automatic logic [63:0] sat_max(input int width);
        return (64'd1 << (width - 1)) - 64'd1;
    endfunction

    // Only the sign bit is set once truncated to WIDTH bits: -2^(WIDTH-1).
    function automatic logic [63:0] sat_min(input int width);
        return 64'd1 << (width - 1);
    endfunction

endpackage

// File: rtl/adder_core.sv
// Combinational signed add/subtract: operand inversion, ripple-carry chain, overflow detect.
module adder_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] in1_i,
    input  logic [WIDTH-1:0] in2_i,
    input  logic             sub_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o,
    output logic             ovf_o
);

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] prop;
    logic [WIDTH-1:0] gen;
    logic [WIDTH:0]   carry;

    assign b_eff = (sub_i == ADD) ? in2_i : ~in2_i;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign prop[i]  = in1_i[i] ^ b_eff[i];
        assign gen[i]   = in1_i[i] & b_eff[i];
        assign sum_o[i] = prop[i] ^ carry[i];
    end

    // NOTE: blocking assignments let each carry[i+1] use the carry[i] just
    // computed; the full default on entry keeps the block free of latches.
    always_comb begin
        carry    = '0;
        carry[0] = (sub_i == SUB);
        for (int i = 0; i < WIDTH; i++) begin
            carry[i+1] = gen[i] | (prop[i] & carry[i]);
        end
    end

    assign cout_o = carry[WIDTH];
    assign ovf_o  = (in1_i[WIDTH-1] == b_eff[WIDTH-1]) &&
                    (sum_o[WIDTH-1] != in1_i[WIDTH-1]);

endmodule

// File: rtl/adder.sv
// Per-lane signed add/subtract with optional saturation and one output register stage.
module adder
    import alu_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter bit SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             sub,
    output logic [WIDTH-1:0] out,
    output logic             ovf,
    output logic             cout
);

    localparam logic [63:0] SAT_MAX_L = sat_max(WIDTH);
    localparam logic [63:0] SAT_MIN_L = sat_min(WIDTH);

    logic [WIDTH-1:0] sum_c;
    logic             cout_c;
    logic             ovf_c;
    logic [WIDTH-1:0] out_d, out_q;
    logic             ovf_q;
    logic             cout_q;

    adder_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .in1_i  (in1),
        .in2_i  (in2),
        .sub_i  (sub),
        .sum_o  (sum_c),
        .cout_o (cout_c),
        .ovf_o  (ovf_c)
    );

    // On overflow the true result has the sign of in1, so clamp toward it.
    always_comb begin
        out_d = sum_c;
        if (SATURATE && ovf_c) begin
            out_d = in1[WIDTH-1] ? SAT_MIN_L[WIDTH-1:0] : SAT_MAX_L[WIDTH-1:0];
        end
    end

    // NOTE: non-blocking assignments for registered state; the synchronous
    // reset clears every flop so nothing downstream ever sees X.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q  <= '0;
            ovf_q  <= 1'b0;
            cout_q <= 1'b0;
        end else begin
            out_q  <= out_d;
            ovf_q  <= ovf_c;
            cout_q <= cout_c;
        end
    end

    assign out  = out_q;
    assign ovf  = ovf_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_adder.sv
// Self-checking bench for adder: directed table, reset/streaming sequences, random vs. integer model.
module tb_adder;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       s;
        logic [7:0] wrap;
        logic [7:0] sat;
        logic       ovf;
        logic       cout;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in1, in2;
    logic       sub;
    logic [7:0] out_w, out_s;
    logic       ovf_w, ovf_s, cout_w, cout_s;

    int total  = 0;
    int passed = 0;

    vec_t vecs[12];
    vec_t exp_q[$];

    always #5 clk = ~clk;

    adder #(.WIDTH(8), .SATURATE(1'b0)) dut_wrap (
        .clk(clk), .rst(rst), .in1(in1), .in2(in2), .sub(sub),
        .out(out_w), .ovf(ovf_w), .cout(cout_w)
    );

    adder #(.WIDTH(8), .SATURATE(1'b1)) dut_sat (
        .clk(clk), .rst(rst), .in1(in1), .in2(in2), .sub(sub),
        .out(out_s), .ovf(ovf_s), .cout(cout_s)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, req);
    endtask

    task automatic check_outs(input string name, input vec_t e);
        check({name, " out(wrap)"}, 32'(out_w), 32'(e.wrap));
        check({name, " out(sat)"},  32'(out_s), 32'(e.sat));
        check({name, " ovf(wrap)"}, 32'(ovf_w), 32'(e.ovf));
        check({name, " ovf(sat)"},  32'(ovf_s), 32'(e.ovf));
        check({name, " cout(wrap)"}, 32'(cout_w), 32'(e.cout));
        check({name, " cout(sat)"},  32'(cout_s), 32'(e.cout));
    endtask

    // Reference: exact integer arithmetic, then range check / clamp / modulo.
    function automatic vec_t model(input logic [7:0] a, input logic [7:0] b, input logic s);
        vec_t        e;
        int          sa, sb, r, ua, ub;
        logic [31:0] rv;
        sa = int'($signed(a));
        sb = int'($signed(b));
        ua = int'(a);
        ub = int'(b);
        r  = s ? sa - sb : sa + sb;
        rv = r;
        e.a    = a;
        e.b    = b;
        e.s    = s;
        e.ovf  = (r > 127) || (r < -128);
        e.wrap = rv[7:0];
        e.sat  = e.ovf ? ((r > 0) ? 8'h7F : 8'h80) : rv[7:0];
        e.cout = s ? (ua >= ub) : (ua + ub >= 256);
        return e;
    endfunction

    function automatic logic [7:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return 8'h80;
            1: return 8'h7F;
            2: return 8'h00;
            3: return 8'hFF;
            default: return 8'($urandom);
        endcase
    endfunction

    task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic s);
        in1 = a;
        in2 = b;
        sub = s;
    endtask

    vec_t zero_v;
    vec_t e;

    initial begin
        //              a            b            s     wrap   sat    ovf   cout
        vecs[0]  = '{8'd12,       8'(-24),     1'b0, 8'hF4, 8'hF4, 1'b0, 1'b0};
        vecs[1]  = '{8'(-45),     8'(-81),     1'b0, 8'h82, 8'h82, 1'b0, 1'b1};
        vecs[2]  = '{8'd23,       8'(-78),     1'b0, 8'hC9, 8'hC9, 1'b0, 1'b0};
        vecs[3]  = '{8'(-48),     8'd61,       1'b0, 8'h0D, 8'h0D, 1'b0, 1'b1};
        vecs[4]  = '{8'd82,       8'd56,       1'b0, 8'h8A, 8'h7F, 1'b1, 1'b0};
        vecs[5]  = '{8'(-23),     8'(-121),    1'b0, 8'h70, 8'h80, 1'b1, 1'b1};
        vecs[6]  = '{8'd12,       8'(-24),     1'b1, 8'h24, 8'h24, 1'b0, 1'b0};
        vecs[7]  = '{8'h80,       8'd1,        1'b1, 8'h7F, 8'h80, 1'b1, 1'b1};
        vecs[8]  = '{8'd0,        8'h80,       1'b1, 8'h80, 8'h7F, 1'b1, 1'b0};
        vecs[9]  = '{8'd0,        8'd0,        1'b1, 8'h00, 8'h00, 1'b0, 1'b1};
        vecs[10] = '{8'd127,      8'd1,        1'b0, 8'h80, 8'h7F, 1'b1, 1'b0};
        vecs[11] = '{8'hFF,       8'd1,        1'b0, 8'h00, 8'h00, 1'b0, 1'b1};
        zero_v   = '{8'd0, 8'd0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0};

        // Reset holds all outputs at zero regardless of operands.
        rst = 1'b1;
        drive(8'd97, 8'd15, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check_outs("reset", zero_v);
        rst = 1'b0;
        @(negedge clk);
        check_outs("first after reset", '{8'd97, 8'd15, 1'b0, 8'h70, 8'h70, 1'b0, 1'b0});

        // Directed table, one operation per cycle.
        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].a, vecs[i].b, vecs[i].s);
            @(negedge clk);
            check_outs($sformatf("vec%0d", i), vecs[i]);
        end

        // Back-to-back stream with a reset pulse in the middle.
        for (int i = 0; i < 4; i++) begin
            if (exp_q.size() > 0) check_outs($sformatf("stream%0d", i - 1), exp_q.pop_front());
            drive(pick_operand(), pick_operand(), 1'($urandom));
            exp_q.push_back(model(in1, in2, sub));
            @(negedge clk);
        end
        check_outs("stream3", exp_q.pop_front());
        rst = 1'b1;
        drive(8'd100, 8'd100, 1'b0);
        @(negedge clk);
        check_outs("mid-stream reset", zero_v);
        rst = 1'b0;
        for (int i = 4; i < 7; i++) begin
            drive(pick_operand(), pick_operand(), 1'($urandom));
            exp_q.push_back(model(in1, in2, sub));
            @(negedge clk);
            check_outs($sformatf("stream%0d", i), exp_q.pop_front());
        end

        // Random operations against the integer model.
        for (int i = 0; i < 300; i++) begin
            drive(pick_operand(), pick_operand(), 1'($urandom));
            e = model(in1, in2, sub);
            @(negedge clk);
            check_outs($sformatf("rand%0d", i), e);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
